force_result_collector: RTL and testbench

- Consumer end of the range-limited core's per-cell force output interface.
- Takes NUM_FILTER force streams (particle ID + 3-axis partial force) from one cell's PE and round-robin arbitrates among them.
- Accumulates each force into a per-particle force cache via a read-modify-write pipeline.
- At end of timestep, streams accumulated forces out to motion update and clears the cache.

---
 rtl/force_result_collector.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_force_result_collector.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/force_result_collector.sv
// -----------------------------------------------------------------------------
// force_result_collector
//
// Consumer end of one cell's force output interface. NUM_FILTER lanes carry
// {pid, Fz, Fy, Fx} words; a round-robin arbiter pops at most one word per
// cycle. Each word is summed into a per-particle force cache through a two-stage
// read-modify-write pipeline. At the end of a timestep the cache is streamed
// out (pid 0..NUM_PARTICLE_PER_CELL-1) and cleared entry by entry.
//
// Ports:
//   clk         single clock
//   rst         asynchronous active-low reset
//   start       pulse, begins a timestep accumulation (honoured in IDLE only)
//   in_data     lane k at bits [k*FORCE_DATA_WIDTH +: FORCE_DATA_WIDTH]
//   in_valid    per-lane word present
//   in_ready    one-hot pop grant (combinational from in_valid)
//   all_done    upstream finished and all force buffers empty
//   out_pid     dump particle ID
//   out_force   dump accumulated force {Fz,Fy,Fx}
//   out_valid   dump word valid
//   out_ready   downstream accepts dump word
//   busy        high in every state except IDLE
//   bad_id_cnt  saturating count of dropped out-of-range IDs
//   state_dbg   current FSM state encoding
//
// Handshake: a transfer happens on a rising clk edge where valid & ready are
// both high. A producer holds valid and its data stable until the transfer;
// ready may depend combinationally on valid. out_valid/out_pid/out_force stay
// stable while out_ready is low.
//
// Build option: define FORCE_SAT_EN to saturate each axis add on signed
// overflow instead of wrapping.
// -----------------------------------------------------------------------------
module force_result_collector #(
  parameter int NUM_PARTICLE_PER_CELL = 100,
  parameter int PARTICLE_ID_WIDTH     = 7,
  parameter int DATA_WIDTH            = 32,
  parameter int NUM_FILTER            = 7,
  parameter int FORCE_DATA_WIDTH      = 3*DATA_WIDTH+PARTICLE_ID_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [NUM_FILTER*FORCE_DATA_WIDTH-1:0] in_data,
  input  logic [NUM_FILTER-1:0]                  in_valid,
  output logic [NUM_FILTER-1:0]                  in_ready,
  input  logic                                   all_done,
  output logic [PARTICLE_ID_WIDTH-1:0]           out_pid,
  output logic [3*DATA_WIDTH-1:0]                out_force,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   busy,
  output logic [15:0]                            bad_id_cnt,
  output logic [2:0]                             state_dbg
);

  localparam int FW     = 3*DATA_WIDTH;
  localparam int LANE_W = (NUM_FILTER > 1) ? $clog2(NUM_FILTER) : 1;
  localparam logic [PARTICLE_ID_WIDTH-1:0] PID_LIMIT =
    PARTICLE_ID_WIDTH'(NUM_PARTICLE_PER_CELL);
  localparam logic [PARTICLE_ID_WIDTH-1:0] LAST_ADDR =
    PARTICLE_ID_WIDTH'(NUM_PARTICLE_PER_CELL-1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_FILTER-1);

  typedef enum logic [2:0] {
    CLEAR = 3'd0,
    IDLE  = 3'd1,
    ACCUM = 3'd2,
    DRAIN = 3'd3,
    DUMP  = 3'd4
  } state_t;

  // One axis add; wraps by default, clamps on signed overflow when enabled.
  function automatic logic [DATA_WIDTH-1:0] add_axis(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH-1:0] s;
    s = a + b;
`ifdef FORCE_SAT_EN
    if ((a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (s[DATA_WIDTH-1] != a[DATA_WIDTH-1])) begin
      s = a[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                          : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
`else
    s = s;
`endif
    return s;
  endfunction

  // Registers
  state_t                       state_q, state_d;
  logic [PARTICLE_ID_WIDTH-1:0] addr_q, addr_d;   // clear / dump address
  logic [LANE_W-1:0]            ptr_q, ptr_d;     // highest-priority lane
  logic                         s1_valid_q, s1_valid_d;
  logic [PARTICLE_ID_WIDTH-1:0] s1_pid_q, s1_pid_d;
  logic [FW-1:0]                s1_force_q, s1_force_d;
  logic                         s2_valid_q, s2_valid_d;
  logic [PARTICLE_ID_WIDTH-1:0] s2_pid_q, s2_pid_d;
  logic [FW-1:0]                s2_force_q, s2_force_d;
  logic [FW-1:0]                s2_rd_q, s2_rd_d;
  logic                         out_valid_q, out_valid_d;
  logic [PARTICLE_ID_WIDTH-1:0] out_pid_q, out_pid_d;
  logic [FW-1:0]                out_force_q, out_force_d;
  logic [15:0]                  bad_cnt_q, bad_cnt_d;

  // Force cache; zeroed by CLEAR after reset and by DUMP after each read-out.
  logic [FW-1:0]                cache_q [NUM_PARTICLE_PER_CELL];
  logic                         cache_we;
  logic [PARTICLE_ID_WIDTH-1:0] cache_waddr;
  logic [FW-1:0]                cache_wdata;

  // Arbiter
  logic [NUM_FILTER-1:0]        grant;
  logic [LANE_W-1:0]            grant_idx;
  logic                         grant_found;
  logic [LANE_W-1:0]            arb_lane;
  int                           arb_idx;

  // Lane decode and pipeline datapath
  logic [FORCE_DATA_WIDTH-1:0]  lane_word;
  logic [PARTICLE_ID_WIDTH-1:0] lane_pid;
  logic [FW-1:0]                lane_force;
  logic                         accept;
  logic [FW-1:0]                s1_rd;
  logic [FW-1:0]                s2_sum;

  // Round-robin search starting at ptr_q; first valid lane wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    arb_idx     = 0;
    arb_lane    = '0;
    for (int i = 0; i < NUM_FILTER; i++) begin
      arb_idx = int'(ptr_q) + i;
      if (arb_idx >= NUM_FILTER) arb_idx = arb_idx - NUM_FILTER;
      arb_lane = LANE_W'(arb_idx);
      if (!grant_found && in_valid[arb_lane]) begin
        grant_found     = 1'b1;
        grant[arb_lane] = 1'b1;
        grant_idx       = arb_lane;
      end
    end
  end

  always_comb begin
    lane_word  = in_data[int'(grant_idx)*FORCE_DATA_WIDTH +: FORCE_DATA_WIDTH];
    lane_pid   = lane_word[FORCE_DATA_WIDTH-1 -: PARTICLE_ID_WIDTH];
    lane_force = lane_word[FW-1:0];
  end

  always_comb begin
    s2_sum = '0;
    for (int a = 0; a < 3; a++) begin
      s2_sum[a*DATA_WIDTH +: DATA_WIDTH] =
        add_axis(s2_rd_q[a*DATA_WIDTH +: DATA_WIDTH], s2_force_q[a*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // S1 read; if S2 is writing the same entry this cycle, the array still holds
  // the stale value, so take S2's sum instead.
  always_comb begin
    if (s2_valid_q && (s2_pid_q == s1_pid_q)) s1_rd = s2_sum;
    else                                      s1_rd = cache_q[s1_pid_q];
  end

  // Next-state, pipeline and output logic
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    ptr_d       = ptr_q;
    s1_valid_d  = 1'b0;
    s1_pid_d    = s1_pid_q;
    s1_force_d  = s1_force_q;
    s2_valid_d  = s1_valid_q;
    s2_pid_d    = s1_pid_q;
    s2_force_d  = s1_force_q;
    s2_rd_d     = s1_rd;
    out_valid_d = out_valid_q;
    out_pid_d   = out_pid_q;
    out_force_d = out_force_q;
    bad_cnt_d   = bad_cnt_q;
    in_ready    = '0;
    accept      = 1'b0;
    cache_we    = s2_valid_q;
    cache_waddr = s2_pid_q;
    cache_wdata = s2_sum;

    case (state_q)
      CLEAR: begin
        cache_we    = 1'b1;
        cache_waddr = addr_q;
        cache_wdata = '0;
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = IDLE;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end

      IDLE: begin
        if (start) state_d = ACCUM;
      end

      ACCUM: begin
        in_ready = grant;
        accept   = grant_found;
        if (accept) begin
          ptr_d = (grant_idx == LAST_LANE) ? '0 : grant_idx + LANE_W'(1);
          if (lane_pid < PID_LIMIT) begin
            s1_valid_d = 1'b1;
            s1_pid_d   = lane_pid;
            s1_force_d = lane_force;
          end else if (bad_cnt_q != 16'hFFFF) begin
            bad_cnt_d = bad_cnt_q + 16'd1;
          end
        end else if (all_done) begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        if (!s1_valid_q && !s2_valid_q) begin
          addr_d  = '0;
          state_d = DUMP;
        end
      end

      DUMP: begin
        // Each word takes one read cycle (valid low) then waits for out_ready.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_pid_d   = addr_q;
          out_force_d = cache_q[addr_q];
        end else if (out_ready) begin
          cache_we    = 1'b1;
          cache_waddr = addr_q;
          cache_wdata = '0;
          out_valid_d = 1'b0;
          if (addr_q == LAST_ADDR) begin
            addr_d  = '0;
            state_d = IDLE;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end

      default: begin
        addr_d  = '0;
        state_d = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= CLEAR;
      addr_q      <= '0;
      ptr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_pid_q    <= '0;
      s1_force_q  <= '0;
      s2_valid_q  <= 1'b0;
      s2_pid_q    <= '0;
      s2_force_q  <= '0;
      s2_rd_q     <= '0;
      out_valid_q <= 1'b0;
      out_pid_q   <= '0;
      out_force_q <= '0;
      bad_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      ptr_q       <= ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_pid_q    <= s1_pid_d;
      s1_force_q  <= s1_force_d;
      s2_valid_q  <= s2_valid_d;
      s2_pid_q    <= s2_pid_d;
      s2_force_q  <= s2_force_d;
      s2_rd_q     <= s2_rd_d;
      out_valid_q <= out_valid_d;
      out_pid_q   <= out_pid_d;
      out_force_q <= out_force_d;
      bad_cnt_q   <= bad_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cache_we) cache_q[cache_waddr] <= cache_wdata;
  end

  assign out_valid  = out_valid_q;
  assign out_pid    = out_pid_q;
  assign out_force  = out_force_q;
  assign busy       = (state_q != IDLE);
  assign bad_id_cnt = bad_cnt_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_force_result_collector.sv
// -----------------------------------------------------------------------------
// tb_force_result_collector
//
// Directed bench for force_result_collector. Inputs are driven and outputs are
// sampled at the falling clock edge. Every dump is compared against a queue of
// expected {pid, force} words built from a small per-particle expectation table.
// -----------------------------------------------------------------------------
module tb_force_result_collector;

  localparam int NP   = 100;
  localparam int PIDW = 7;
  localparam int DW   = 32;
  localparam int NF   = 7;
  localparam int FDW  = 3*DW+PIDW;
  localparam int FW   = 3*DW;

  // Clock / reset / DUT signals
  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              all_done = 1'b0;
  logic              out_ready = 1'b0;
  logic [NF*FDW-1:0] in_data = '0;
  logic [NF-1:0]     in_valid = '0;
  logic [NF-1:0]     in_ready;
  logic [PIDW-1:0]   out_pid;
  logic [FW-1:0]     out_force;
  logic              out_valid;
  logic              busy;
  logic [15:0]       bad_id_cnt;
  logic [2:0]        state_dbg;

  // Scoreboard
  int                n_checks = 0;
  int                n_pass   = 0;
  logic [PIDW+FW-1:0] exp_q[$];
  logic [FW-1:0]     exp_force [NP];

  always #5 clk = ~clk;

  force_result_collector dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .all_done   (all_done),
    .out_pid    (out_pid),
    .out_force  (out_force),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .bad_id_cnt (bad_id_cnt),
    .state_dbg  (state_dbg)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [FW-1:0] frc(input logic [31:0] fz, input logic [31:0] fy,
                                        input logic [31:0] fx);
    return {fz, fy, fx};
  endfunction

  task automatic set_lane(input int lane, input int pid, input logic [31:0] fz,
                          input logic [31:0] fy, input logic [31:0] fx);
    in_data[lane*FDW +: FDW] = {PIDW'(pid), fz, fy, fx};
  endtask

  // Counts cycles from reset release until busy falls.
  task automatic wait_clear();
    int cnt;
    cnt = 0;
    rst = 1'b1;
    in_valid = '1;
    while (busy && cnt < 300) begin
      @(negedge clk);
      cnt++;
      if (cnt == 50) begin
        #1;
        check("clear_no_ready", in_ready, '0);
      end
    end
    in_valid = '0;
    check("clear_cycles", cnt, 100);
  endtask

  task automatic start_ts();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1'b1);
  endtask

  // Offers n identical words on one lane, expecting it to be granted each cycle.
  task automatic send_words(input int lane, input int pid, input logic [31:0] fz,
                            input logic [31:0] fy, input logic [31:0] fx, input int n);
    int sent;
    int cyc;
    logic [NF-1:0] e;
    sent = 0;
    cyc  = 0;
    e = '0;
    e[lane] = 1'b1;
    set_lane(lane, pid, fz, fy, fx);
    in_valid[lane] = 1'b1;
    while (sent < n && cyc < 200) begin
      #1;
      check("grant_single", in_ready, e);
      if (in_ready[lane]) sent++;
      @(negedge clk);
      cyc++;
    end
    in_valid[lane] = 1'b0;
    check("words_sent", sent, n);
  endtask

  // Raises all_done, collects the full dump and compares it to exp_force.
  // When hold_cycles > 0, out_ready is held low for that many cycles once
  // the word for hold_pid is presented.
  task automatic dump_and_check(input int hold_pid, input int hold_cycles);
    int got;
    int cyc;
    int hold_left;
    logic [PIDW+FW-1:0] snap;
    logic [PIDW+FW-1:0] w;
    exp_q.delete();
    for (int p = 0; p < NP; p++) exp_q.push_back({PIDW'(p), exp_force[p]});
    for (int p = 0; p < NP; p++) exp_force[p] = '0;
    got = 0;
    cyc = 0;
    hold_left = hold_cycles;
    snap = '0;
    all_done  = 1'b1;
    out_ready = 1'b1;
    while (got < NP && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (hold_left > 0 && hold_left < hold_cycles) begin
        check("dump_hold_stable", {out_valid, out_pid, out_force}, {1'b1, snap});
        out_ready = 1'b0;
        hold_left--;
      end else if (out_valid) begin
        if (hold_left > 0 && hold_left == hold_cycles && int'(out_pid) == hold_pid) begin
          snap = {out_pid, out_force};
          out_ready = 1'b0;
          hold_left--;
        end else begin
          out_ready = 1'b1;
          w = exp_q.pop_front();
          check("dump_word", {out_pid, out_force}, w);
          got++;
        end
      end
    end
    check("dump_count", got, NP);
    all_done = 1'b0;
    @(negedge clk);
    check("dump_idle", busy, 1'b0);
  endtask

  initial begin
    int rem0;
    int rem3;
    int cyc;
    int exp_lane;
    logic [NF-1:0] e;

    for (int p = 0; p < NP; p++) exp_force[p] = '0;

    // Reset state, with lanes offering words
    in_valid = '1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 1'b1);
    check("rst_in_ready", in_ready, '0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_pid", out_pid, '0);
    check("rst_out_force", out_force, '0);
    check("rst_bad_id_cnt", bad_id_cnt, 16'd0);
    wait_clear();

    // Empty timestep: all zeros dumped
    start_ts();
    dump_and_check(127, 0);

    // Lanes 0 and 3 contend, pid 5 Fx=1, 10 words each; hold at addr 3 in dump
    start_ts();
    set_lane(0, 5, 32'd0, 32'd0, 32'd1);
    set_lane(3, 5, 32'd0, 32'd0, 32'd1);
    rem0 = 10;
    rem3 = 10;
    cyc = 0;
    exp_lane = 0;
    while ((rem0 > 0 || rem3 > 0) && cyc < 100) begin
      in_valid = '0;
      in_valid[0] = (rem0 > 0);
      in_valid[3] = (rem3 > 0);
      #1;
      e = '0;
      e[exp_lane] = 1'b1;
      check("rr_grant", in_ready, e);
      if (exp_lane == 0) begin
        rem0--;
        exp_lane = 3;
      end else begin
        rem3--;
        exp_lane = 0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = '0;
    repeat (3) @(negedge clk);
    exp_force[5] = frc(32'd0, 32'd0, 32'd20);
    dump_and_check(3, 5);

    // Forwarding, bad IDs and overflow in one timestep; pid 5 must be zero now
    start_ts();
    send_words(2, 7, 32'd0, 32'hFFFF_FFFE, 32'd3, 4);
    send_words(6, 100, 32'd1, 32'd1, 32'd1, 1);
    send_words(6, 127, 32'd1, 32'd1, 32'd1, 1);
    send_words(1, 1, 32'd0, 32'd0, 32'h7FFF_FFFF, 1);
    send_words(1, 1, 32'd0, 32'd0, 32'd1, 1);
    repeat (3) @(negedge clk);
    check("bad_id_cnt", bad_id_cnt, 16'd2);
    exp_force[7] = frc(32'd0, 32'hFFFF_FFF8, 32'd12);
`ifdef FORCE_SAT_EN
    exp_force[1] = frc(32'd0, 32'd0, 32'h7FFF_FFFF);
`else
    exp_force[1] = frc(32'd0, 32'd0, 32'h8000_0000);
`endif
    dump_and_check(127, 0);

    // Reset during accumulation aborts everything and reruns CLEAR
    start_ts();
    set_lane(0, 9, 32'd0, 32'd0, 32'd5);
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    rst = 1'b0;
    #1;
    check("abort_busy", busy, 1'b1);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_bad_id_cnt", bad_id_cnt, 16'd0);
    @(negedge clk);
    wait_clear();
    start_ts();
    dump_and_check(127, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
